dso_meas_eth_send: RTL and testbench

DSO_MEAS_ETH_SEND -- requirements
Module: dso_meas_eth_send

---
 rtl/dso_meas_eth_send.sv | 234 +++++++++++++++++++++++
 tb/tb_dso_meas_eth_send.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dso_meas_eth_send.sv
// Periodic / on-demand measurement reporter feeding a UDP sender on the GMII TX clock.
// Optional build macro MEAS_TX_CHKSUM_EN appends an XOR checksum word to the payload.
`timescale 1ns/1ps

module dso_meas_eth_send #(
    parameter logic [31:0] PERIOD_CYCLES  = 32'd125_000_000,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd65535
) (
    input  logic        eth_tx_clk,
    input  logic        rst,
    input  logic        poll_req,
    input  logic [19:0] ad_freq,
    input  logic [7:0]  ad_vpp,
    input  logic [7:0]  ad_max,
    input  logic [7:0]  ad_min,
    input  logic        tx_req,
    input  logic        tx_done,
    output logic        tx_start_en,
    output logic [31:0] tx_data,
    output logic [15:0] tx_byte_num,
    output logic        busy,
    output logic [7:0]  abort_cnt
);

    // state     | meaning
    // S_IDLE    | waiting for a pending report; snapshots inputs on exit
    // S_START   | one-cycle tx_start_en pulse, seq advances
    // S_SEND    | presenting payload words on tx_req
    // S_WAIT_DONE | waiting for tx_done or timeout

`ifdef MEAS_TX_CHKSUM_EN
    localparam logic [1:0]  LAST_IDX = 2'd3;
    localparam logic [15:0] BYTE_NUM = 16'd16;
`else
    localparam logic [1:0]  LAST_IDX = 2'd2;
    localparam logic [15:0] BYTE_NUM = 16'd12;
`endif
    localparam logic [31:0] MAGIC = 32'h44534F4D;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_SEND      = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_period_cnt;
    logic        w_tick;
    logic        r_pending;
    logic [15:0] r_to_cnt;
    logic [15:0] w_to_cnt_inc;
    logic        w_to_expire;
    logic [7:0]  r_seq;
    logic [7:0]  r_abort_cnt;
    logic [1:0]  r_word_idx;
    logic        w_last_word;
    logic [31:0] r_tx_data;
    logic [31:0] w_word1;
    logic [31:0] w_word2;
    logic [31:0] w_next_word;
    logic        w_snapshot;

    logic [19:0] r_snap_freq;
    logic [7:0]  r_snap_vpp;
    logic [7:0]  r_snap_max;
    logic [7:0]  r_snap_min;
    logic [7:0]  r_snap_seq;

    assign w_tick       = (r_period_cnt == PERIOD_CYCLES - 32'd1);
    assign w_snapshot   = (r_state == S_IDLE) && r_pending;
    assign w_to_cnt_inc = r_to_cnt + 16'd1;
    assign w_to_expire  = (w_to_cnt_inc == TIMEOUT_CYCLES);
    assign w_last_word  = (r_word_idx == LAST_IDX);

    always_ff @(posedge eth_tx_clk or posedge rst) begin
        if (rst) begin
            r_period_cnt <= 32'd0;
        end else if (w_tick) begin
            r_period_cnt <= 32'd0;
        end else begin
            r_period_cnt <= r_period_cnt + 32'd1;
        end
    end

    // A new event on the snapshot cycle wins over the clear: it gets its own packet.
    always_ff @(posedge eth_tx_clk or posedge rst) begin
        if (rst) begin
            r_pending <= 1'b0;
        end else if (w_tick || poll_req) begin
            r_pending <= 1'b1;
        end else if (w_snapshot) begin
            r_pending <= 1'b0;
        end
    end

    // seq is captured here so word1 carries the value before START advances it.
    always_ff @(posedge eth_tx_clk or posedge rst) begin
        if (rst) begin
            r_snap_freq <= 20'h0;
            r_snap_vpp  <= 8'h0;
            r_snap_max  <= 8'h0;
            r_snap_min  <= 8'h0;
            r_snap_seq  <= 8'h0;
        end else if (w_snapshot) begin
            r_snap_freq <= ad_freq;
            r_snap_vpp  <= ad_vpp;
            r_snap_max  <= ad_max;
            r_snap_min  <= ad_min;
            r_snap_seq  <= r_seq;
        end
    end

    always_ff @(posedge eth_tx_clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        tx_start_en = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (r_pending) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                tx_start_en = 1'b1;
                w_state_nxt = S_SEND;
            end
            S_SEND: begin
                if (tx_req && w_last_word) begin
                    w_state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (tx_done || w_to_expire) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge eth_tx_clk or posedge rst) begin
        if (rst) begin
            r_seq <= 8'h0;
        end else if (r_state == S_START) begin
            r_seq <= r_seq + 8'h1;
        end
    end

    always_ff @(posedge eth_tx_clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= 16'd0;
        end else if (r_state == S_WAIT_DONE) begin
            r_to_cnt <= w_to_cnt_inc;
        end else begin
            r_to_cnt <= 16'd0;
        end
    end

    always_ff @(posedge eth_tx_clk or posedge rst) begin
        if (rst) begin
            r_abort_cnt <= 8'h0;
        end else if ((r_state == S_WAIT_DONE) && !tx_done && w_to_expire
                     && (r_abort_cnt != 8'hFF)) begin
            r_abort_cnt <= r_abort_cnt + 8'h1;
        end
    end

    assign w_word1 = {4'h0, r_snap_seq, r_snap_freq};
    assign w_word2 = {r_snap_vpp, r_snap_max, r_snap_min, 8'h00};

    always_comb begin
        w_next_word = 32'h0;
        case (r_word_idx)
            2'd0:    w_next_word = w_word1;
            2'd1:    w_next_word = w_word2;
`ifdef MEAS_TX_CHKSUM_EN
            2'd2:    w_next_word = MAGIC ^ w_word1 ^ w_word2;
`endif
            default: w_next_word = 32'h0;
        endcase
    end

    // Requests past the last word present zero and leave the index parked.
    always_ff @(posedge eth_tx_clk or posedge rst) begin
        if (rst) begin
            r_tx_data  <= 32'h0;
            r_word_idx <= 2'd0;
        end else begin
            case (r_state)
                S_START: begin
                    r_tx_data  <= MAGIC;
                    r_word_idx <= 2'd0;
                end
                S_SEND: begin
                    if (tx_req) begin
                        if (w_last_word) begin
                            r_tx_data <= 32'h0;
                        end else begin
                            r_tx_data  <= w_next_word;
                            r_word_idx <= r_word_idx + 2'd1;
                        end
                    end
                end
                S_WAIT_DONE: begin
                    if (tx_req) begin
                        r_tx_data <= 32'h0;
                    end
                end
                default: begin
                    r_tx_data <= r_tx_data;
                end
            endcase
        end
    end

    assign tx_data     = r_tx_data;
    assign tx_byte_num = BYTE_NUM;
    assign abort_cnt   = r_abort_cnt;

endmodule

// File: tb/tb_dso_meas_eth_send.sv
// Scoreboard bench for dso_meas_eth_send: poll-driven instance plus a short-period instance.
`timescale 1ns/1ps

module tb_dso_meas_eth_send;

`ifdef MEAS_TX_CHKSUM_EN
    localparam int          NW     = 4;
    localparam logic [15:0] BN_EXP = 16'd16;
`else
    localparam int          NW     = 3;
    localparam logic [15:0] BN_EXP = 16'd12;
`endif
    localparam logic [31:0] MAGIC = 32'h44534F4D;

    logic        clk = 1'b0;
    logic        rst, p_rst, poll_req, tx_req, tx_done;
    logic [19:0] ad_freq;
    logic [7:0]  ad_vpp, ad_max, ad_min;
    logic        d_start, d_busy, p_start, p_busy;
    logic [31:0] d_data, p_data;
    logic [15:0] d_bnum, p_bnum;
    logic [7:0]  d_abort, p_abort;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  seq_d   = 8'h0;

    always #4 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dso_meas_eth_send #(.PERIOD_CYCLES(32'd1_000_000), .TIMEOUT_CYCLES(16'd50)) u_dut (
        .eth_tx_clk(clk), .rst(rst), .poll_req(poll_req), .ad_freq(ad_freq),
        .ad_vpp(ad_vpp), .ad_max(ad_max), .ad_min(ad_min), .tx_req(tx_req),
        .tx_done(tx_done), .tx_start_en(d_start), .tx_data(d_data),
        .tx_byte_num(d_bnum), .busy(d_busy), .abort_cnt(d_abort)
    );

    dso_meas_eth_send #(.PERIOD_CYCLES(32'd100), .TIMEOUT_CYCLES(16'd50)) u_per (
        .eth_tx_clk(clk), .rst(p_rst), .poll_req(1'b0), .ad_freq(ad_freq),
        .ad_vpp(ad_vpp), .ad_max(ad_max), .ad_min(ad_min), .tx_req(tx_req),
        .tx_done(tx_done), .tx_start_en(p_start), .tx_data(p_data),
        .tx_byte_num(p_bnum), .busy(p_busy), .abort_cnt(p_abort)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic f_start(input bit sel);
        return sel ? p_start : d_start;
    endfunction
    function automatic logic f_busy(input bit sel);
        return sel ? p_busy : d_busy;
    endfunction
    function automatic logic [31:0] f_data(input bit sel);
        return sel ? p_data : d_data;
    endfunction

    task automatic push_pkt(input logic [7:0] seq);
        logic [31:0] w1, w2;
        w1 = {4'h0, seq, ad_freq};
        w2 = {ad_vpp, ad_max, ad_min, 8'h00};
        exp_q.push_back(MAGIC);
        exp_q.push_back(w1);
        exp_q.push_back(w2);
        if (NW == 4) exp_q.push_back(MAGIC ^ w1 ^ w2);
    endtask

    task automatic poll();
        poll_req = 1'b1;
        @(negedge clk);
        poll_req = 1'b0;
    endtask

    // Services one packet; returns the cycle its tx_start_en was seen.
    task automatic serve(input bit sel, input bit hold_done, input int n_mid_polls,
                         input int exp_to, output int start_cyc);
        int t;
        int n;
        logic [31:0] w0;
        t = 0;
        start_cyc = -1;
        while (!f_start(sel) && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("start_seen", {31'h0, f_start(sel)}, 32'h1);
        if (!f_start(sel)) begin
            repeat (NW) void'(exp_q.pop_front());
            return;
        end
        start_cyc = cyc;
        chk("byte_num", {16'h0, sel ? p_bnum : d_bnum}, {16'h0, BN_EXP});
        @(negedge clk);
        chk("start_one_cycle", {31'h0, f_start(sel)}, 32'h0);
        w0 = exp_q.pop_front();
        chk("word0", f_data(sel), w0);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        chk("done_ignored_busy", {31'h0, f_busy(sel)}, 32'h1);
        chk("done_ignored_data", f_data(sel), w0);
        if (n_mid_polls > 0) begin
            for (int i = 0; i < n_mid_polls; i++) begin
                poll();
                @(negedge clk);
            end
            ad_freq = 20'hABCDE;
            ad_vpp  = 8'h11;
            ad_max  = 8'h22;
            ad_min  = 8'h33;
        end
        tx_req = 1'b1;
        for (int k = 1; k <= NW; k++) begin
            @(negedge clk);
            if (k < NW) chk("word_n", f_data(sel), exp_q.pop_front());
            else        chk("tail_zero", f_data(sel), 32'h0);
        end
        tx_req = 1'b0;
        if (!hold_done) begin
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
        end else begin
            n = 1;
            while (n < 200) begin
                @(negedge clk);
                if (!f_busy(sel)) break;
                n++;
            end
            chk("timeout_cycles", n, exp_to);
        end
    endtask

    initial begin
        #(8 * 120000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int sc, prev, cnt;
        rst = 1'b1; p_rst = 1'b1; poll_req = 1'b0; tx_req = 1'b0; tx_done = 1'b0;
        ad_freq = 20'h0; ad_vpp = 8'h0; ad_max = 8'h0; ad_min = 8'h0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'h0, d_busy}, 32'h0);
        chk("rst_data", d_data, 32'h0);
        chk("rst_start", {31'h0, d_start}, 32'h0);
        chk("rst_abort", {24'h0, d_abort}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", {31'h0, d_busy}, 32'h0);

        // Reference payload, then all-ones frequency boundary.
        ad_freq = 20'h12345; ad_vpp = 8'h80; ad_max = 8'hC0; ad_min = 8'h40;
        push_pkt(seq_d); seq_d++;
        poll();
        serve(0, 0, 0, 0, sc);
        @(negedge clk);
        chk("busy_after_done", {31'h0, d_busy}, 32'h0);

        ad_freq = 20'hFFFFF; ad_vpp = 8'h01; ad_max = 8'h02; ad_min = 8'h03;
        push_pkt(seq_d); seq_d++;
        poll();
        serve(0, 0, 0, 0, sc);

        // Three polls mid-packet plus input change: one follow-up with the new values.
        push_pkt(seq_d); seq_d++;
        poll();
        serve(0, 0, 3, 0, sc);
        push_pkt(seq_d); seq_d++;
        serve(0, 0, 0, 0, sc);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (d_start) cnt++;
        end
        chk("no_extra_packet", cnt, 0);

        push_pkt(seq_d); seq_d++;
        poll();
        serve(0, 1, 0, 50, sc);
        chk("abort_one", {24'h0, d_abort}, 32'h1);

        // Reset in the middle of SEND.
        poll();
        cnt = 0;
        while (!d_start && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        @(negedge clk);
        tx_req = 1'b1;
        @(negedge clk);
        tx_req = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_busy", {31'h0, d_busy}, 32'h0);
        chk("midrst_data", d_data, 32'h0);
        chk("midrst_abort", {24'h0, d_abort}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        seq_d = 8'h0;
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (d_start) cnt++;
        end
        chk("no_start_after_rst", cnt, 0);
        ad_freq = 20'h00001; ad_vpp = 8'hFF; ad_max = 8'hFF; ad_min = 8'h00;
        push_pkt(seq_d); seq_d++;
        poll();
        serve(0, 0, 0, 0, sc);

        // Timeout saturation.
        for (int i = 0; i < 300; i++) begin
            push_pkt(seq_d); seq_d++;
            poll();
            serve(0, 1, 0, 50, sc);
            chk("abort_sat", {24'h0, d_abort}, (i + 1 > 255) ? 32'd255 : i + 1);
        end

        // Periodic instance: 100-cycle cadence, seq wraps after 256 packets.
        ad_freq = 20'h5A5A5; ad_vpp = 8'h7E; ad_max = 8'hBF; ad_min = 8'h41;
        p_rst = 1'b0;
        prev = -1;
        for (int i = 0; i < 260; i++) begin
            push_pkt(8'(i));
            serve(1, 0, 0, 0, sc);
            if (prev >= 0 && sc >= 0) chk("period_interval", sc - prev, 100);
            prev = sc;
        end
        chk("per_abort", {24'h0, p_abort}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
